// File: rtl/nexus_work_scheduler_if.sv
// nexus_work_scheduler_if: host-side work offer and found-nonce handshake of the work scheduler.
interface nexus_work_scheduler_if;
    logic          WorkValid;
    logic          WorkReady;
    logic [1727:0] WorkPkt;
    logic [63:0]   StartNonce;
    logic [31:0]   NonceCount;
    logic          FoundValid;
    logic [63:0]   FoundNonce;
    logic          FoundPop;
    logic          Busy;
    logic          Done;
    logic          Overflow;
    modport master (
        output WorkValid, WorkPkt, StartNonce, NonceCount, FoundPop,
        input  WorkReady, FoundValid, FoundNonce, Busy, Done, Overflow
    );
    modport slave (
        input  WorkValid, WorkPkt, StartNonce, NonceCount, FoundPop,
        output WorkReady, FoundValid, FoundNonce, Busy, Done, Overflow
    );
endinterface

// File: rtl/nexus_work_scheduler.sv
// nexus_work_scheduler: runs one NexusHashTransform core over a bounded nonce range per work unit.
// Defining NONCE_STATS_EN adds a saturating HashCount of nonces issued.
module nexus_work_scheduler #(
    parameter int PIPE_LATENCY = 388,
    parameter int HASHERS      = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int RST_CYCLES   = 2
) (
    input  logic                   clk,
    input  logic                   nHashRst,
    nexus_work_scheduler_if.slave  host,
    output logic [1727:0]          CoreWorkPkt,
    output logic [63:0]            CoreNonce,
    output logic                   CorenHashRst,
    input  logic [63:0]            CoreNonceOut,
    input  logic                   CoreFound
`ifdef NONCE_STATS_EN
    ,
    output logic [47:0]            HashCount
`endif
);
    localparam int SH = $clog2(HASHERS);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
    state_t state, nextState;
    logic [32:0] cnt, cntNext, runCycles;
    logic [63:0] base;
    logic [31:0] count;
    logic [63:0] mem [FIFO_DEPTH];
    logic [AW:0] wp, rp;
    logic accept, zero, last, done, doneNext, overflow, hit, full, empty, pop, push, drop;
    assign accept    = host.WorkValid && host.WorkReady;
    assign zero      = host.NonceCount == '0;
    assign last      = cnt == '0;
    assign runCycles = ({1'b0, count} + 33'(HASHERS - 1)) >> SH;
    assign host.WorkReady = state != LOAD;
    assign host.Busy      = state != IDLE;
    assign host.Done      = done;
    assign host.Overflow  = overflow;
    assign CorenHashRst   = state == RUN || state == DRAIN;
    // Offset from base makes the range check immune to nonce-space wrap.
    assign hit   = CoreFound && CorenHashRst && (CoreNonceOut - base) < {32'b0, count};
    assign empty = wp == rp;
    assign full  = wp == {~rp[AW], rp[AW-1:0]};
    assign pop   = host.FoundPop && !empty;
    assign push  = hit && (!full || pop);
    assign drop  = hit && full && !pop;
    assign host.FoundValid = !empty;
    assign host.FoundNonce = mem[rp[AW-1:0]];
    always_comb begin
        nextState = state;
        cntNext   = cnt - 33'd1;
        doneNext  = 1'b0;
        if (accept) begin
            nextState = zero ? IDLE : LOAD;
            cntNext   = 33'(RST_CYCLES - 1);
            doneNext  = zero;
        end else if (state != IDLE && last) begin
            nextState = state == LOAD ? RUN : state == RUN ? DRAIN : IDLE;
            cntNext   = state == LOAD ? runCycles - 33'd1 : 33'(PIPE_LATENCY - 1);
            doneNext  = state == DRAIN;
        end
    end
    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            state       <= IDLE;
            cnt         <= '0;
            base        <= '0;
            count       <= '0;
            CoreWorkPkt <= '0;
            CoreNonce   <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            wp          <= '0;
            rp          <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            state    <= nextState;
            cnt      <= cntNext;
            done     <= doneNext;
            overflow <= accept ? 1'b0 : drop ? 1'b1 : overflow;
            if (accept) begin
                base        <= host.StartNonce;
                count       <= host.NonceCount;
                CoreWorkPkt <= host.WorkPkt;
            end
            CoreNonce <= accept ? host.StartNonce : state == RUN ? CoreNonce + 64'(HASHERS) : CoreNonce;
            if (push) begin
                mem[wp[AW-1:0]] <= CoreNonceOut;
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
        end
    end
`ifdef NONCE_STATS_EN
    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) HashCount <= '0;
        else if (state == RUN)
            HashCount <= HashCount > 48'hFFFF_FFFF_FFFF - 48'(HASHERS) ? '1 : HashCount + 48'(HASHERS);
    end
`endif
endmodule

// File: tb/tb_nexus_work_scheduler.sv
// tb_nexus_work_scheduler: directed checks of the work scheduler, default build plus a HASHERS=2 instance.
module tb_nexus_work_scheduler;
    logic clk = 1'b0;
    logic nHashRst = 1'b0;
    always #5 clk = ~clk;
    nexus_work_scheduler_if hif ();
    nexus_work_scheduler_if hif2 ();
    logic [1727:0] coreWorkPkt, coreWorkPkt2;
    logic [63:0] coreNonce, coreNonce2;
    logic [63:0] coreNonceOut = '0, coreNonceOut2 = '0;
    logic coreRst, coreRst2;
    logic coreFound = 1'b0, coreFound2 = 1'b0;
    int nChecks = 0, nFails = 0, early = 0;
`ifdef NONCE_STATS_EN
    logic [47:0] hashCount, hashCount2;
`endif
    nexus_work_scheduler dut (
        .clk(clk), .nHashRst(nHashRst), .host(hif),
        .CoreWorkPkt(coreWorkPkt), .CoreNonce(coreNonce), .CorenHashRst(coreRst),
        .CoreNonceOut(coreNonceOut), .CoreFound(coreFound)
`ifdef NONCE_STATS_EN
        , .HashCount(hashCount)
`endif
    );
    nexus_work_scheduler #(.PIPE_LATENCY(3), .HASHERS(2)) dut2 (
        .clk(clk), .nHashRst(nHashRst), .host(hif2),
        .CoreWorkPkt(coreWorkPkt2), .CoreNonce(coreNonce2), .CorenHashRst(coreRst2),
        .CoreNonceOut(coreNonceOut2), .CoreFound(coreFound2)
`ifdef NONCE_STATS_EN
        , .HashCount(hashCount2)
`endif
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    task automatic offer(logic [63:0] s, logic [31:0] n);
        hif.StartNonce = s;
        hif.NonceCount = n;
        hif.WorkValid = 1'b1;
        tick();
        hif.WorkValid = 1'b0;
    endtask
    task automatic hit(logic [63:0] n);
        coreNonceOut = n;
        coreFound = 1'b1;
        tick();
        coreFound = 1'b0;
    endtask
    task automatic popHead();
        hif.FoundPop = 1'b1;
        tick();
        hif.FoundPop = 1'b0;
    endtask
    initial begin
        hif.WorkValid = 1'b0; hif.WorkPkt = '0; hif.StartNonce = '0; hif.NonceCount = '0; hif.FoundPop = 1'b0;
        hif2.WorkValid = 1'b0; hif2.WorkPkt = '0; hif2.StartNonce = '0; hif2.NonceCount = '0; hif2.FoundPop = 1'b0;
        #12;
        check("rst WorkReady", 64'(hif.WorkReady), 64'd1);
        check("rst Busy", 64'(hif.Busy), 64'd0);
        check("rst FoundValid", 64'(hif.FoundValid), 64'd0);
        check("rst Done", 64'(hif.Done), 64'd0);
        check("rst Overflow", 64'(hif.Overflow), 64'd0);
        check("rst CorenHashRst", 64'(coreRst), 64'd0);
        check("rst CoreNonce", coreNonce, 64'd0);
        check("rst FoundNonce", hif.FoundNonce, 64'd0);
        nHashRst = 1'b1;
        tick();
        // basic range: load, run 256, drain 388
        hif.WorkPkt = {64'hDEAD_BEEF_0123_4567, 1600'd0, 64'h89AB_CDEF_FEDC_BA98};
        offer(64'h1_FCAF_C000, 32'h100);
        check("t1 CoreNonce at accept", coreNonce, 64'h1_FCAF_C000);
        check("t1 pkt hi", coreWorkPkt[1727:1664], 64'hDEAD_BEEF_0123_4567);
        check("t1 pkt lo", coreWorkPkt[63:0], 64'h89AB_CDEF_FEDC_BA98);
        check("t1 WorkReady in LOAD", 64'(hif.WorkReady), 64'd0);
        check("t1 Busy", 64'(hif.Busy), 64'd1);
        tick();
        check("t1 core rst cyc1", 64'(coreRst), 64'd0);
        tick();
        check("t1 core run", 64'(coreRst), 64'd1);
        check("t1 first nonce", coreNonce, 64'h1_FCAF_C000);
        tick();
        check("t1 second nonce", coreNonce, 64'h1_FCAF_C001);
        for (int i = 4; i <= 645; i++) begin
            if (i == 300) begin
                coreFound = 1'b1;
                coreNonceOut = 64'h1_FCAF_C044;
            end
            tick();
            coreFound = 1'b0;
            if (hif.Done) early++;
        end
        check("t1 no early Done", 64'(early), 64'd0);
        check("t1 Busy before end", 64'(hif.Busy), 64'd1);
        tick();
        check("t1 Done", 64'(hif.Done), 64'd1);
        check("t1 idle", 64'(hif.Busy), 64'd0);
        check("t1 core rst idle", 64'(coreRst), 64'd0);
        check("t1 FoundValid", 64'(hif.FoundValid), 64'd1);
        check("t1 FoundNonce", hif.FoundNonce, 64'h1_FCAF_C044);
        check("t1 nonce end", coreNonce, 64'h1_FCAF_C100);
        tick();
        check("t1 Done pulse", 64'(hif.Done), 64'd0);
        popHead();
        check("t1 popped", 64'(hif.FoundValid), 64'd0);
        // range filter boundaries and LOAD discard
        offer(64'h1000, 32'h10);
        hit(64'h1001);
        check("t2 LOAD hit dropped", 64'(hif.FoundValid), 64'd0);
        tick();
        hit(64'h1010);
        check("t2 end+1 discarded", 64'(hif.FoundValid), 64'd0);
        check("t2 no Overflow", 64'(hif.Overflow), 64'd0);
        hit(64'h100F);
        check("t2 last in range", hif.FoundNonce, 64'h100F);
        popHead();
        check("t2 popped", 64'(hif.FoundValid), 64'd0);
        // abort mid-RUN into a wrapping range, then fill and overflow the FIFO
        offer(64'hFFFF_FFFF_FFFF_FFFE, 32'd4);
        check("t3 abort rst", 64'(coreRst), 64'd0);
        check("t3 abort nonce", coreNonce, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t3 abort no Done", 64'(hif.Done), 64'd0);
        tick();
        check("t3 rst cyc2", 64'(coreRst), 64'd0);
        check("t3 no Done", 64'(hif.Done), 64'd0);
        tick();
        check("t3 run", 64'(coreRst), 64'd1);
        hit(64'h1);
        check("t3 wrap hit", hif.FoundNonce, 64'h1);
        hit(64'h2);
        hit(64'h0);
        hit(64'hFFFF_FFFF_FFFF_FFFE);
        hit(64'hFFFF_FFFF_FFFF_FFFF);
        check("t4 full no Overflow", 64'(hif.Overflow), 64'd0);
        hit(64'h0);
        check("t4 Overflow", 64'(hif.Overflow), 64'd1);
        coreNonceOut = 64'h1;
        coreFound = 1'b1;
        popHead();
        coreFound = 1'b0;
        check("t4 pop+push Overflow kept", 64'(hif.Overflow), 64'd1);
        check("t4 head0", hif.FoundNonce, 64'h0);
        popHead();
        check("t4 head1", hif.FoundNonce, 64'hFFFF_FFFF_FFFF_FFFE);
        popHead();
        check("t4 head2", hif.FoundNonce, 64'hFFFF_FFFF_FFFF_FFFF);
        popHead();
        check("t4 head3", hif.FoundNonce, 64'h1);
        check("t4 still valid", 64'(hif.FoundValid), 64'd1);
        popHead();
        check("t4 empty", 64'(hif.FoundValid), 64'd0);
        // accept clears Overflow; async reset mid-DRAIN
        offer(64'h5000, 32'h20);
        check("t5 Overflow cleared", 64'(hif.Overflow), 64'd0);
        tick();
        tick();
        hit(64'h5007);
        check("t5 hit", hif.FoundNonce, 64'h5007);
        for (int i = 4; i <= 40; i++) tick();
        check("t5 DRAIN busy", 64'(hif.Busy), 64'd1);
        check("t5 DRAIN core on", 64'(coreRst), 64'd1);
        #2 nHashRst = 1'b0;
        #1;
        check("t5 rst Busy", 64'(hif.Busy), 64'd0);
        check("t5 rst FoundValid", 64'(hif.FoundValid), 64'd0);
        check("t5 rst FoundNonce", hif.FoundNonce, 64'd0);
        check("t5 rst core", 64'(coreRst), 64'd0);
        check("t5 rst CoreNonce", coreNonce, 64'd0);
        check("t5 rst WorkReady", 64'(hif.WorkReady), 64'd1);
        #3 nHashRst = 1'b1;
        tick();
        check("t5 no Done after rst", 64'(hif.Done), 64'd0);
        check("t5 stays idle", 64'(hif.Busy), 64'd0);
        // zero-length work
        offer(64'h77, 32'd0);
        check("t6 zero Done", 64'(hif.Done), 64'd1);
        check("t6 zero idle", 64'(hif.Busy), 64'd0);
        check("t6 zero nonce", coreNonce, 64'h77);
        tick();
        check("t6 zero Done pulse", 64'(hif.Done), 64'd0);
        // HASHERS=2: 5 nonces -> 3 run cycles, latency 3
        hif2.StartNonce = 64'h10;
        hif2.NonceCount = 32'd5;
        hif2.WorkValid = 1'b1;
        tick();
        hif2.WorkValid = 1'b0;
        early = 0;
        for (int i = 1; i <= 7; i++) begin
            coreFound2 = i == 4 || i == 5;
            coreNonceOut2 = 64'h10 + 64'(i);
            tick();
            if (i == 3) check("h2 nonce step", coreNonce2, 64'h12);
            if (hif2.Done) early++;
        end
        coreFound2 = 1'b0;
        check("h2 no early Done", 64'(early), 64'd0);
        tick();
        check("h2 Done", 64'(hif2.Done), 64'd1);
        check("h2 nonce end", coreNonce2, 64'h16);
        check("h2 hit kept", hif2.FoundNonce, 64'h14);
        hif2.FoundPop = 1'b1;
        tick();
        hif2.FoundPop = 1'b0;
        check("h2 out-of-range dropped", 64'(hif2.FoundValid), 64'd0);
`ifdef NONCE_STATS_EN
        check("h2 HashCount", 64'(hashCount2), 64'd6);
        hif2.NonceCount = 32'd0;
        hif2.WorkValid = 1'b1;
        tick();
        hif2.WorkValid = 1'b0;
        check("h2 zero Done", 64'(hif2.Done), 64'd1);
        tick();
        check("h2 HashCount kept", 64'(hashCount2), 64'd6);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
